// File: rtl/core_pkg.sv
// core_pkg: shared types and helpers for the RV32 core pipeline.
// Contents:
//   REG_ADDR_WIDTH : architectural register address width (x0..x31).
//   fwd_sel_e      : EX operand source select (register file, MEM, WB).
//   hc_state_e     : hazard control FSM states.
//   reg_match      : true when a writing stage targets a given source.
package core_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HC_RUN      = 1'b0,
    HC_MEM_WAIT = 1'b1
  } hc_state_e;

  // x0 is hard-wired to zero, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic                      we,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock, counts on the rising edge.
//   rst_n : asynchronous active-low clear.
//   inc_i : count this cycle.
//   cnt_o : current count.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline control for the 5-stage RV32 core.
// Produces per-stage register enables and bubble flushes, EX forwarding
// selects and ID-stage WB bypass, resolving load-use / RAW hazards, taken
// branch/jump redirects and multi-cycle data-memory freezes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset.
//   id_rs_addr_i/used_i : ID source addresses {rs2,rs1} and read flags.
//   ex_rs_addr_i        : EX source addresses {rs2,rs1}.
//   ex_*/mem_*/wb_*     : destination and write/load/access flags per stage.
//   ex_redirect_i       : EX resolved a taken branch or jump.
//   stage_we_o          : enables {MEM/WB, EX/MEM, ID/EX, IF/ID, PC}.
//   flush_o             : {ID/EX bubble, IF/ID bubble}.
//   fwd_a/b_sel_o       : EX operand sources (fwd_sel_e encoding).
//   id_bypass_o         : {rs2,rs1} take WB write data in ID.
//   stall_cycles_o      : saturating count of cycles with PC enable low.
//   flush_count_o       : saturating count of applied redirects.
module hazard_ctrl_unit
  import core_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int FWD_EN    = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*REG_ADDR_WIDTH-1:0] id_rs_addr_i,
  input  logic [1:0]                  id_rs_used_i,
  input  logic [2*REG_ADDR_WIDTH-1:0] ex_rs_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]   ex_rd_addr_i,
  input  logic                        ex_RegWrite_i,
  input  logic                        ex_MemRead_i,
  input  logic                        ex_redirect_i,
  input  logic [REG_ADDR_WIDTH-1:0]   mem_rd_addr_i,
  input  logic                        mem_RegWrite_i,
  input  logic                        mem_access_i,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_rd_addr_i,
  input  logic                        wb_RegWrite_i,
  output logic [4:0]                  stage_we_o,
  output logic [1:0]                  flush_o,
  output logic [1:0]                  fwd_a_sel_o,
  output logic [1:0]                  fwd_b_sel_o,
  output logic [1:0]                  id_bypass_o,
  output logic [CNT_WIDTH-1:0]        stall_cycles_o,
  output logic [CNT_WIDTH-1:0]        flush_count_o
);

  localparam int W  = REG_ADDR_WIDTH;
  // Keep the wait counter at least one bit wide when there is no freeze.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  hc_state_e     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          freeze;

  logic [1:0] id_ex_m, id_mem_m, id_wb_m;
  logic [1:0] ex_mem_m, ex_wb_m;
  logic [1:0] fwd_sel [2];
  logic       lu, raw, hazard;
  logic       redirect_applied;

  always_comb begin
    id_ex_m  = '0;
    id_mem_m = '0;
    id_wb_m  = '0;
    ex_mem_m = '0;
    ex_wb_m  = '0;
    for (int s = 0; s < 2; s++) begin
      id_ex_m[s]  = id_rs_used_i[s] &&
                    reg_match(ex_RegWrite_i, ex_rd_addr_i, id_rs_addr_i[s*W +: W]);
      id_mem_m[s] = id_rs_used_i[s] &&
                    reg_match(mem_RegWrite_i, mem_rd_addr_i, id_rs_addr_i[s*W +: W]);
      id_wb_m[s]  = id_rs_used_i[s] &&
                    reg_match(wb_RegWrite_i, wb_rd_addr_i, id_rs_addr_i[s*W +: W]);
      ex_mem_m[s] = reg_match(mem_RegWrite_i, mem_rd_addr_i, ex_rs_addr_i[s*W +: W]);
      ex_wb_m[s]  = reg_match(wb_RegWrite_i, wb_rd_addr_i, ex_rs_addr_i[s*W +: W]);
    end
  end

  // With forwarding only a load result is too late for EX; without it any
  // in-flight producer of a used source must drain first.
  assign lu     = ex_MemRead_i && (|id_ex_m);
  assign raw    = |(id_ex_m | id_mem_m | id_wb_m);
  assign hazard = (FWD_EN != 0) ? lu : raw;

  // Memory freeze FSM: the access cycle in HC_RUN is the first frozen cycle,
  // so HC_MEM_WAIT only needs MEM_LAT-2 more before the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HC_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    freeze   = 1'b0;
    case (state)
      HC_RUN: begin
        if (mem_access_i && (MEM_LAT > 1)) begin
          freeze   = 1'b1;
          cnt_nx   = CNT_LOAD;
          state_nx = HC_MEM_WAIT;
        end
      end
      HC_MEM_WAIT: begin
        if (cnt != '0) begin
          freeze = 1'b1;
          cnt_nx = cnt - CW'(1);
        end else begin
          state_nx = HC_RUN;
        end
      end
      default: state_nx = HC_RUN;
    endcase
  end

  // Priority: reset, freeze, redirect (ID holds a wrong-path instruction,
  // so its hazard is moot), hazard stall, normal flow.
  always_comb begin
    stage_we_o       = 5'b11111;
    flush_o          = 2'b00;
    redirect_applied = 1'b0;
    if (!rst_n) begin
      stage_we_o = 5'b00000;
    end else if (freeze) begin
      stage_we_o = 5'b00000;
    end else if (ex_redirect_i) begin
      flush_o          = 2'b11;
      redirect_applied = 1'b1;
    end else if (hazard) begin
      stage_we_o = 5'b11100;
      flush_o    = 2'b10;
    end
  end

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fwd_sel[s] = FWD_NONE;
      if (rst_n && (FWD_EN != 0)) begin
        if (ex_mem_m[s])     fwd_sel[s] = FWD_MEM;
        else if (ex_wb_m[s]) fwd_sel[s] = FWD_WB;
      end
    end
  end

  assign fwd_a_sel_o = fwd_sel[0];
  assign fwd_b_sel_o = fwd_sel[1];
  assign id_bypass_o = (rst_n && (FWD_EN != 0)) ? id_wb_m : 2'b00;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (~stage_we_o[0]),
    .cnt_o (stall_cycles_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (redirect_applied),
    .cnt_o (flush_count_o)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances share one stimulus stream
//   0: MEM_LAT=1, FWD_EN=1, CNT_WIDTH=32
//   1: MEM_LAT=4, FWD_EN=1, CNT_WIDTH=32
//   2: MEM_LAT=1, FWD_EN=0, CNT_WIDTH=4
// A behavioural model predicts every output of each instance every cycle;
// directed literal checks pin the model to hand-computed values.
module tb_hazard_ctrl_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic [9:0] id_rs_addr;
  logic [1:0] id_rs_used;
  logic [9:0] ex_rs_addr;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_rw, ex_mr, ex_redir, mem_rw, mem_acc, wb_rw;

  logic [4:0]  we  [3];
  logic [1:0]  fl  [3];
  logic [1:0]  fa  [3];
  logic [1:0]  fb  [3];
  logic [1:0]  byp [3];
  logic [31:0] sc_a, sc_m, fc_a, fc_m;
  logic [3:0]  sc_i, fc_i;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit #(.MEM_LAT(1), .FWD_EN(1), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs_addr_i(id_rs_addr), .id_rs_used_i(id_rs_used),
    .ex_rs_addr_i(ex_rs_addr), .ex_rd_addr_i(ex_rd), .ex_RegWrite_i(ex_rw),
    .ex_MemRead_i(ex_mr), .ex_redirect_i(ex_redir), .mem_rd_addr_i(mem_rd),
    .mem_RegWrite_i(mem_rw), .mem_access_i(mem_acc), .wb_rd_addr_i(wb_rd),
    .wb_RegWrite_i(wb_rw), .stage_we_o(we[0]), .flush_o(fl[0]), .fwd_a_sel_o(fa[0]),
    .fwd_b_sel_o(fb[0]), .id_bypass_o(byp[0]), .stall_cycles_o(sc_a), .flush_count_o(fc_a));

  hazard_ctrl_unit #(.MEM_LAT(4), .FWD_EN(1), .CNT_WIDTH(32)) dut_m (
    .clk(clk), .rst_n(rst_n), .id_rs_addr_i(id_rs_addr), .id_rs_used_i(id_rs_used),
    .ex_rs_addr_i(ex_rs_addr), .ex_rd_addr_i(ex_rd), .ex_RegWrite_i(ex_rw),
    .ex_MemRead_i(ex_mr), .ex_redirect_i(ex_redir), .mem_rd_addr_i(mem_rd),
    .mem_RegWrite_i(mem_rw), .mem_access_i(mem_acc), .wb_rd_addr_i(wb_rd),
    .wb_RegWrite_i(wb_rw), .stage_we_o(we[1]), .flush_o(fl[1]), .fwd_a_sel_o(fa[1]),
    .fwd_b_sel_o(fb[1]), .id_bypass_o(byp[1]), .stall_cycles_o(sc_m), .flush_count_o(fc_m));

  hazard_ctrl_unit #(.MEM_LAT(1), .FWD_EN(0), .CNT_WIDTH(4)) dut_i (
    .clk(clk), .rst_n(rst_n), .id_rs_addr_i(id_rs_addr), .id_rs_used_i(id_rs_used),
    .ex_rs_addr_i(ex_rs_addr), .ex_rd_addr_i(ex_rd), .ex_RegWrite_i(ex_rw),
    .ex_MemRead_i(ex_mr), .ex_redirect_i(ex_redir), .mem_rd_addr_i(mem_rd),
    .mem_RegWrite_i(mem_rw), .mem_access_i(mem_acc), .wb_rd_addr_i(wb_rd),
    .wb_RegWrite_i(wb_rw), .stage_we_o(we[2]), .flush_o(fl[2]), .fwd_a_sel_o(fa[2]),
    .fwd_b_sel_o(fb[2]), .id_bypass_o(byp[2]), .stall_cycles_o(sc_i), .flush_count_o(fc_i));

  // ---------------- behavioural model ----------------
  int lat_c [3] = '{1, 4, 1};
  bit fwd_c [3] = '{1'b1, 1'b1, 1'b0};
  int cw_c  [3] = '{32, 32, 4};

  // busy = cycles the current memory instruction still spends in MEM,
  // counting the present cycle; 0 when no multi-cycle access is in flight.
  int     busy [3] = '{0, 0, 0};
  longint m_sc [3] = '{0, 0, 0};
  longint m_fc [3] = '{0, 0, 0};

  function automatic bit writes(input bit rw, input logic [4:0] rd, input logic [4:0] r);
    return rw && (rd != 5'd0) && (rd == r);
  endfunction

  function automatic void model(input int c, output logic [4:0] ewe, output logic [1:0] efl,
                                output logic [1:0] efa, output logic [1:0] efb,
                                output logic [1:0] eby, output bit redir_app);
    logic [4:0] ids [2];
    logic [4:0] exs [2];
    bit lu, raw, haz, frozen;
    logic [1:0] sel [2];
    ids[0] = id_rs_addr[4:0];  ids[1] = id_rs_addr[9:5];
    exs[0] = ex_rs_addr[4:0];  exs[1] = ex_rs_addr[9:5];
    ewe = 5'b11111; efl = 2'b00; efa = 2'b00; efb = 2'b00; eby = 2'b00;
    redir_app = 1'b0;
    if (!rst_n) begin
      ewe = 5'b00000;
      return;
    end
    lu = 1'b0; raw = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (id_rs_used[s]) begin
        if (writes(ex_rw, ex_rd, ids[s]) && ex_mr) lu = 1'b1;
        if (writes(ex_rw, ex_rd, ids[s]) || writes(mem_rw, mem_rd, ids[s]) ||
            writes(wb_rw, wb_rd, ids[s])) raw = 1'b1;
        if (fwd_c[c] && writes(wb_rw, wb_rd, ids[s])) eby[s] = 1'b1;
      end
      sel[s] = 2'b00;
      if (fwd_c[c]) begin
        if (writes(mem_rw, mem_rd, exs[s]))     sel[s] = 2'b01;
        else if (writes(wb_rw, wb_rd, exs[s]))  sel[s] = 2'b10;
      end
    end
    efa = sel[0]; efb = sel[1];
    haz    = fwd_c[c] ? lu : raw;
    frozen = (busy[c] == 0 && mem_acc && lat_c[c] > 1) || (busy[c] > 1);
    if (frozen) begin
      ewe = 5'b00000;
    end else if (ex_redir) begin
      efl = 2'b11; redir_app = 1'b1;
    end else if (haz) begin
      ewe = 5'b11100; efl = 2'b10;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] ewe;
    logic [1:0] efl, efa, efb, eby;
    bit ra;
    longint mx;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        busy[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        model(c, ewe, efl, efa, efb, eby, ra);
        mx = (64'sd1 <<< cw_c[c]) - 1;
        if (!ewe[0] && m_sc[c] < mx) m_sc[c]++;
        if (ra && m_fc[c] < mx) m_fc[c]++;
        if (busy[c] == 0 && mem_acc && lat_c[c] > 1) busy[c] = lat_c[c] - 1;
        else if (busy[c] > 0) busy[c]--;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] ewe;
    logic [1:0] efl, efa, efb, eby;
    bit ra;
    logic [63:0] asc, afc;
    for (int c = 0; c < 3; c++) begin
      model(c, ewe, efl, efa, efb, eby, ra);
      case (c)
        0:       begin asc = 64'(sc_a); afc = 64'(fc_a); end
        1:       begin asc = 64'(sc_m); afc = 64'(fc_m); end
        default: begin asc = 64'(sc_i); afc = 64'(fc_i); end
      endcase
      chk($sformatf("d%0d_we", c),    64'(we[c]),  64'(ewe));
      chk($sformatf("d%0d_flush", c), 64'(fl[c]),  64'(efl));
      chk($sformatf("d%0d_fwd_a", c), 64'(fa[c]),  64'(efa));
      chk($sformatf("d%0d_fwd_b", c), 64'(fb[c]),  64'(efb));
      chk($sformatf("d%0d_bypass", c), 64'(byp[c]), 64'(eby));
      chk($sformatf("d%0d_stall_cnt", c), asc, 64'(m_sc[c]));
      chk($sformatf("d%0d_flush_cnt", c), afc, 64'(m_fc[c]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    id_rs_addr = '0; id_rs_used = '0; ex_rs_addr = '0;
    ex_rd = '0; ex_rw = 1'b0; ex_mr = 1'b0; ex_redir = 1'b0;
    mem_rd = '0; mem_rw = 1'b0; mem_acc = 1'b0;
    wb_rd = '0; wb_rw = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input bit redir);
    idle();
    ex_rd = 5'd6; ex_rw = 1'b1; ex_mr = 1'b1; ex_redir = redir;
    id_rs_addr = {5'd6, 5'd1}; id_rs_used = 2'b10;
  endtask

  initial begin
    longint s0, f0;
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we",        64'(we[0]), 64'd0);
    chk("rst_stall_cnt", 64'(sc_a),  64'd0);
    next(); rst_n = 1'b1;
    @(negedge clk);
    chk("run_we", 64'(we[0]), 64'h1f);

    // Forwarding: x5 in MEM and WB, EX rs1 = x5
    next(); idle();
    mem_rd = 5'd5; mem_rw = 1'b1; wb_rd = 5'd5; wb_rw = 1'b1; ex_rs_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("fwd_mem_pri", 64'(fa[0]), 64'(FWD_MEM));
    chk("fwd_b_none",  64'(fb[0]), 64'(FWD_NONE));
    next(); mem_rw = 1'b0;
    @(negedge clk);
    chk("fwd_wb", 64'(fa[0]), 64'(FWD_WB));

    // x0 destinations everywhere
    next(); idle();
    ex_rw = 1'b1; ex_mr = 1'b1; mem_rw = 1'b1; wb_rw = 1'b1; id_rs_used = 2'b11;
    @(negedge clk);
    chk("x0_fwd_a",  64'(fa[0]),  64'd0);
    chk("x0_bypass", 64'(byp[0]), 64'd0);
    chk("x0_we_ilk", 64'(we[2]),  64'h1f);

    // Load-use: lw x6 in EX, ID reads rs2 = x6
    next(); load_use(1'b0);
    @(negedge clk);
    chk("lu_we",    64'(we[0]), 64'h1c);
    chk("lu_flush", 64'(fl[0]), 64'h2);
    s0 = longint'(sc_a);
    next(); idle();
    @(negedge clk);
    chk("lu_stall_inc", 64'(sc_a), 64'(s0 + 1));

    // Redirect overrides load-use
    next(); load_use(1'b1);
    @(negedge clk);
    chk("redir_we",    64'(we[0]), 64'h1f);
    chk("redir_flush", 64'(fl[0]), 64'h3);
    f0 = longint'(fc_a);
    next(); idle();
    @(negedge clk);
    chk("redir_cnt_inc", 64'(fc_a), 64'(f0 + 1));

    // MEM_LAT=4: two back-to-back accesses, each 3 frozen cycles + release
    next(); mem_acc = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("mw_frozen", 64'(we[1]), 64'd0);
        next();
      end
      @(negedge clk);
      chk("mw_release",   64'(we[1]), 64'h1f);
      chk("mw_lat1_free", 64'(we[0]), 64'h1f);
      next();
    end
    // Third access: reset during its second frozen cycle
    @(negedge clk);
    chk("mw_frozen3", 64'(we[1]), 64'd0);
    next(); rst_n = 1'b0;
    @(negedge clk);
    chk("mw_rst_we",  64'(we[1]), 64'd0);
    chk("mw_rst_cnt", 64'(sc_m),  64'd0);
    next(); rst_n = 1'b1; idle();
    @(negedge clk);
    chk("mw_after_rst", 64'(we[1]), 64'h1f);

    // Interlock: x7 in WB, ID reads rs1 = x7
    next(); idle();
    wb_rd = 5'd7; wb_rw = 1'b1; id_rs_addr = {5'd0, 5'd7}; id_rs_used = 2'b01;
    @(negedge clk);
    chk("ilk_we",        64'(we[2]),  64'h1c);
    chk("ilk_flush",     64'(fl[2]),  64'h2);
    chk("ilk_bypass",    64'(byp[2]), 64'd0);
    chk("fwd_bypass",    64'(byp[0]), 64'h1);
    chk("fwd_no_stall",  64'(we[0]),  64'h1f);

    // Hold the RAW to saturate the 4-bit stall counter
    repeat (20) @(negedge clk);
    chk("sat_15", 64'(sc_i), 64'd15);
    next(); idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
